// File: rtl/seq_pkg.sv
// Shared types, mode encodings and the instruction-decode table for the microsequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_pkg;

  // Width of a microstate index and the state entered out of reset / on a bad decode.
  localparam int STATE_W = 7;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t RESET_STATE = '0;

  // Next-state mode field emitted by the microstore.
  typedef enum logic [2:0] {
    N_ENCODE = 3'd0,
    N_JUMP   = 3'd1,
    N_INC    = 3'd2,
    N_CJ_INC = 3'd3,
    N_CJ_ENC = 3'd4,
    N_WAIT   = 3'd5,
    N_CALL   = 3'd6,
    N_RETURN = 3'd7
  } n_mode_e;

  // Condition source select; the two constant entries let the microcode force a branch.
  typedef enum logic [1:0] {
    CS_MOC  = 2'd0,
    CS_COND = 2'd1,
    CS_ONE  = 2'd2,
    CS_ZERO = 2'd3
  } cond_sel_e;

  // MIPS-style opcode and funct codes recognised by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // One decode entry: opcode match, optional funct match, and the microstate to dispatch to.
  typedef struct packed {
    logic [5:0] opcode;
    logic       use_funct;
    logic [5:0] funct;
    state_t     target;
  } enc_entry_t;

  localparam int ENC_ENTRIES = 6;

  // Dispatch table; keys are unique, so entry order carries no priority meaning.
  localparam enc_entry_t ENC_TABLE [ENC_ENTRIES] = '{
    '{opcode: OP_RTYPE, use_funct: 1'b1, funct: FN_ADDU, target: 7'd6},
    '{opcode: OP_RTYPE, use_funct: 1'b1, funct: FN_SUBU, target: 7'd16},
    '{opcode: OP_ADDIU, use_funct: 1'b0, funct: 6'h00,   target: 7'd17},
    '{opcode: OP_LW,    use_funct: 1'b0, funct: 6'h00,   target: 7'd7},
    '{opcode: OP_SW,    use_funct: 1'b0, funct: 6'h00,   target: 7'd11},
    '{opcode: OP_BEQ,   use_funct: 1'b0, funct: 6'h00,   target: 7'd12}
  };

  // True when an instruction word hits the given table entry.
  function automatic logic entry_hit(input enc_entry_t e, input logic [5:0] op, input logic [5:0] fn);
    return (op == e.opcode) && (!e.use_funct || (fn == e.funct));
  endfunction

endpackage

// File: rtl/instruction_encoder.sv
// Maps an instruction word to the first microstate of its execution routine.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever ir is.
module instruction_encoder
  import seq_pkg::*;
(
  input  logic [31:0] ir,
  output state_t      state,
  output logic        match
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir_bits;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Register and immediate fields do not affect dispatch.
  assign unused_ir_bits = ^ir[25:6];

  // Table search; an unmatched word falls back to the fetch state with match low.
  always_comb begin
    state = RESET_STATE;
    match = 1'b0;
    for (int i = ENC_ENTRIES - 1; i >= 0; i--) begin
      if (entry_hit(ENC_TABLE[i], opcode, funct)) begin
        state = ENC_TABLE[i].target;
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/next_state_sequencer.sv
// Microstate sequencer: picks the next state from decode, increment, literal or link register.
// Latency: one cycle from microstore fields to current_state; fault pulses align with the new state.
// Backpressure: WAIT mode holds the state until the condition is met or the watchdog fires.
module next_state_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT    = 15,
  parameter state_t      TIMEOUT_STATE = 7'd5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         n_mode,
  input  logic               inv,
  input  logic [1:0]         cond_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [31:0]        ir,
  input  logic               moc,
  input  logic               cond,
  output logic [STATE_W-1:0] current_state,
  output logic               illegal_op,
  output logic               mem_timeout
);

  localparam int WAIT_CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(WAIT_LIMIT);

  n_mode_e                 mode;
  cond_sel_e               csel;
  logic                    sel_raw;
  logic                    c;
  state_t                  inc;
  state_t                  enc_state;
  logic                    enc_match;

  state_t                  link;
  logic                    link_valid;
  logic [WAIT_CNT_W-1:0]   wait_cnt;

  state_t                  next_state;
  state_t                  next_link;
  logic                    next_link_valid;
  logic [WAIT_CNT_W-1:0]   next_wait_cnt;
  logic                    next_illegal;
  logic                    next_timeout;

  assign mode = n_mode_e'(n_mode);
  assign csel = cond_sel_e'(cond_sel);

  // Increment wraps silently at the top of the state space.
  assign inc = current_state + state_t'(1);

  instruction_encoder u_encoder (
    .ir    (ir),
    .state (enc_state),
    .match (enc_match)
  );

  // Branch condition: chosen source, optionally inverted.
  always_comb begin
    sel_raw = 1'b0;
    case (csel)
      CS_MOC:  sel_raw = moc;
      CS_COND: sel_raw = cond;
      CS_ONE:  sel_raw = 1'b1;
      CS_ZERO: sel_raw = 1'b0;
      default: sel_raw = 1'b0;
    endcase
    c = sel_raw ^ inv;
  end

  // Next-state selection; the wait counter is cleared by default so any non-holding cycle resets it.
  always_comb begin
    next_state      = current_state;
    next_link       = link;
    next_link_valid = link_valid;
    next_wait_cnt   = '0;
    next_illegal    = 1'b0;
    next_timeout    = 1'b0;

    case (mode)
      N_ENCODE: begin
        next_state   = enc_state;
        next_illegal = !enc_match;
      end

      N_JUMP: begin
        next_state = cr;
      end

      N_INC: begin
        next_state = inc;
      end

      N_CJ_INC: begin
        next_state = c ? cr : inc;
      end

      N_CJ_ENC: begin
        // A taken branch never consults the decoder, so it cannot flag a bad opcode.
        if (c) begin
          next_state = cr;
        end else begin
          next_state   = enc_state;
          next_illegal = !enc_match;
        end
      end

      N_WAIT: begin
        // Completion wins over expiry when both land in the same cycle.
        if (c) begin
          next_state = inc;
        end else if (wait_cnt == WAIT_MAX) begin
          next_state   = TIMEOUT_STATE;
          next_timeout = 1'b1;
        end else begin
          next_state    = current_state;
          next_wait_cnt = wait_cnt + 1'b1;
        end
      end

      N_CALL: begin
        // Single link slot: a nested call simply replaces the saved return point.
        next_state      = cr;
        next_link       = inc;
        next_link_valid = 1'b1;
      end

      N_RETURN: begin
        if (link_valid) begin
          next_state      = link;
          next_link_valid = 1'b0;
        end else begin
          next_state   = RESET_STATE;
          next_illegal = 1'b1;
        end
      end

      default: begin
        next_state = current_state;
      end
    endcase
  end

  // State, link and watchdog registers; fault flags are registered so they line up with the new state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_state <= RESET_STATE;
      link          <= RESET_STATE;
      link_valid    <= 1'b0;
      wait_cnt      <= '0;
      illegal_op    <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      current_state <= next_state;
      link          <= next_link;
      link_valid    <= next_link_valid;
      wait_cnt      <= next_wait_cnt;
      illegal_op    <= next_illegal;
      mem_timeout   <= next_timeout;
    end
  end

  // Decode faults and watchdog expiry come from disjoint modes, so they can never coincide.
  a_fault_exclusive: assert property (@(posedge clk) disable iff (!reset) !(illegal_op && mem_timeout));

endmodule

// File: tb/tb_next_state_sequencer.sv
module tb_next_state_sequencer;
  import seq_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  n_mode;
  logic        inv;
  logic [1:0]  cond_sel;
  logic [6:0]  cr;
  logic [31:0] ir;
  logic        moc;
  logic        cond;
  logic [6:0]  current_state;
  logic        illegal_op;
  logic        mem_timeout;

  typedef struct packed {
    logic [2:0]  mode;
    logic        inv;
    logic [1:0]  cs;
    logic [6:0]  cr;
    logic [31:0] ir;
    logic        moc;
    logic        cond;
    logic [6:0]  st;
    logic        ill;
    logic        to;
  } row_t;

  typedef struct packed {
    logic [6:0] st;
    logic       ill;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  next_state_sequencer #(.WAIT_LIMIT(15), .TIMEOUT_STATE(7'd5)) dut (
    .clk           (clk),
    .reset         (reset),
    .n_mode        (n_mode),
    .inv           (inv),
    .cond_sel      (cond_sel),
    .cr            (cr),
    .ir            (ir),
    .moc           (moc),
    .cond          (cond),
    .current_state (current_state),
    .illegal_op    (illegal_op),
    .mem_timeout   (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t r(input logic [2:0] m, input logic i, input logic [1:0] cs,
                             input logic [6:0] c, input logic [31:0] w, input logic mo,
                             input logic cd, input logic [6:0] st, input logic ill, input logic to);
    row_t x;
    x.mode = m; x.inv = i; x.cs = cs; x.cr = c; x.ir = w; x.moc = mo; x.cond = cd;
    x.st = st; x.ill = ill; x.to = to;
    return x;
  endfunction

  // Apply one microstore word, record what should appear after the edge, then step past it.
  task automatic drive(input row_t x);
    exp_t e;
    n_mode = x.mode; inv = x.inv; cond_sel = x.cs; cr = x.cr; ir = x.ir; moc = x.moc; cond = x.cond;
    e.st = x.st; e.ill = x.ill; e.to = x.to;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    n_mode = N_JUMP; inv = 1'b0; cond_sel = CS_ZERO; cr = 7'd0; ir = 32'h0; moc = 1'b0; cond = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (current_state !== 7'd0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %0d/%b/%b want 0/0/0", current_state, illegal_op, mem_timeout);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(r(N_JUMP, 0, CS_ZERO, 7'd12, 32'h0, 0, 0, 7'd12, 0, 0));
    e = sb.pop_front();
    vectors++;
    if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
      errors++;
      $display("FAIL reset_jump: got %0d/%b/%b want %0d/%b/%b", current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
    end
    drive(r(N_CALL, 0, CS_ZERO, 7'd30, 32'h0, 0, 0, 7'd30, 0, 0));
    e = sb.pop_front();
    vectors++;
    if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
      errors++;
      $display("FAIL reset_call: got %0d/%b/%b want %0d/%b/%b", current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
    end
    // Reset asserted between edges must clear the state at once.
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (current_state !== 7'd0) begin
      errors++;
      $display("FAIL reset_async: got state=%0d want 0", current_state);
    end
    #1 reset = 1'b1;
    // The link saved by the interrupted call must be gone.
    drive(r(N_RETURN, 0, CS_ZERO, 7'd0, 32'h0, 0, 0, 7'd0, 1, 0));
    e = sb.pop_front();
    vectors++;
    if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
      errors++;
      $display("FAIL reset_link_cleared: got %0d/%b/%b want %0d/%b/%b", current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
    end
  endtask

  task automatic test_encode();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h8C000000, 0, 0, 7'd7,  0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h00000021, 0, 0, 7'd6,  0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'hFC000000, 0, 0, 7'd0,  1, 0));
    rows.push_back(r(N_JUMP,   0, CS_ZERO, 7'd3,  32'h0,        0, 0, 7'd3,  0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h00000023, 0, 0, 7'd16, 0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h24000000, 0, 0, 7'd17, 0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'hAC000000, 0, 0, 7'd11, 0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h10000000, 0, 0, 7'd12, 0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h00000022, 0, 0, 7'd0,  1, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h8C000021, 0, 0, 7'd7,  0, 0));
    rows.push_back(r(N_ENCODE, 0, CS_ZERO, 7'd0,  32'h84000021, 0, 0, 7'd0,  1, 0));
    rows.push_back(r(N_CJ_ENC, 0, CS_ONE,  7'd44, 32'h8C000000, 0, 0, 7'd44, 0, 0));
    rows.push_back(r(N_CJ_ENC, 0, CS_ZERO, 7'd44, 32'h8C000000, 0, 0, 7'd7,  0, 0));
    rows.push_back(r(N_CJ_ENC, 0, CS_ZERO, 7'd44, 32'hFC000000, 0, 0, 7'd0,  1, 0));
    rows.push_back(r(N_CJ_ENC, 0, CS_ONE,  7'd44, 32'hFC000000, 0, 0, 7'd44, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
        errors++;
        $display("FAIL encode[%0d]: got %0d/%b/%b want %0d/%b/%b", i, current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
      end
    end
  endtask

  task automatic test_wait_moc();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(N_JUMP, 0, CS_MOC, 7'd8, 32'h0, 0, 0, 7'd8, 0, 0));
    for (int k = 0; k < 3; k++) rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 0, 0, 7'd8, 0, 0));
    rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 1, 0, 7'd9, 0, 0));
    rows.push_back(r(N_WAIT, 1, CS_COND, 7'd0, 32'h0, 0, 0, 7'd10, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
        errors++;
        $display("FAIL wait_moc[%0d]: got %0d/%b/%b want %0d/%b/%b", i, current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
      end
    end
  endtask

  task automatic test_wait_timeout();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(N_JUMP, 0, CS_MOC, 7'd8, 32'h0, 0, 0, 7'd8, 0, 0));
    for (int k = 0; k < 10; k++) rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 0, 0, 7'd8, 0, 0));
    rows.push_back(r(N_JUMP, 0, CS_MOC, 7'd8, 32'h0, 0, 0, 7'd8, 0, 0));
    for (int k = 0; k < 15; k++) rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 0, 0, 7'd8, 0, 0));
    rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 0, 0, 7'd5, 0, 1));
    rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 0, 0, 7'd5, 0, 0));
    rows.push_back(r(N_JUMP, 0, CS_MOC, 7'd8, 32'h0, 0, 0, 7'd8, 0, 0));
    for (int k = 0; k < 15; k++) rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 0, 0, 7'd8, 0, 0));
    rows.push_back(r(N_WAIT, 0, CS_MOC, 7'd0, 32'h0, 1, 0, 7'd9, 0, 0));
    rows.push_back(r(N_INC,  0, CS_MOC, 7'd0, 32'h0, 0, 0, 7'd10, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
        errors++;
        $display("FAIL wait_timeout[%0d]: got %0d/%b/%b want %0d/%b/%b", i, current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
      end
    end
  endtask

  task automatic test_call_return();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(N_JUMP,   0, CS_ZERO, 7'd20,  32'h0, 0, 0, 7'd20, 0, 0));
    rows.push_back(r(N_CALL,   0, CS_ZERO, 7'd40,  32'h0, 0, 0, 7'd40, 0, 0));
    rows.push_back(r(N_RETURN, 0, CS_ZERO, 7'd0,   32'h0, 0, 0, 7'd21, 0, 0));
    rows.push_back(r(N_RETURN, 0, CS_ZERO, 7'd0,   32'h0, 0, 0, 7'd0,  1, 0));
    rows.push_back(r(N_JUMP,   0, CS_ZERO, 7'd50,  32'h0, 0, 0, 7'd50, 0, 0));
    rows.push_back(r(N_CALL,   0, CS_ZERO, 7'd60,  32'h0, 0, 0, 7'd60, 0, 0));
    rows.push_back(r(N_CALL,   0, CS_ZERO, 7'd70,  32'h0, 0, 0, 7'd70, 0, 0));
    rows.push_back(r(N_RETURN, 0, CS_ZERO, 7'd0,   32'h0, 0, 0, 7'd61, 0, 0));
    rows.push_back(r(N_RETURN, 0, CS_ZERO, 7'd0,   32'h0, 0, 0, 7'd0,  1, 0));
    rows.push_back(r(N_JUMP,   0, CS_ZERO, 7'd127, 32'h0, 0, 0, 7'd127, 0, 0));
    rows.push_back(r(N_CALL,   0, CS_ZERO, 7'd5,   32'h0, 0, 0, 7'd5,  0, 0));
    rows.push_back(r(N_RETURN, 0, CS_ZERO, 7'd0,   32'h0, 0, 0, 7'd0,  0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
        errors++;
        $display("FAIL call_return[%0d]: got %0d/%b/%b want %0d/%b/%b", i, current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
      end
    end
  endtask

  task automatic test_inc_cond();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(N_JUMP,   0, CS_ZERO, 7'd127, 32'h0, 0, 0, 7'd127, 0, 0));
    rows.push_back(r(N_INC,    0, CS_ZERO, 7'd0,   32'h0, 0, 0, 7'd0,   0, 0));
    rows.push_back(r(N_INC,    0, CS_ZERO, 7'd0,   32'h0, 0, 0, 7'd1,   0, 0));
    rows.push_back(r(N_CJ_INC, 1, CS_ONE,  7'd99,  32'h0, 0, 0, 7'd2,   0, 0));
    rows.push_back(r(N_CJ_INC, 0, CS_ONE,  7'd99,  32'h0, 0, 0, 7'd99,  0, 0));
    rows.push_back(r(N_CJ_INC, 0, CS_COND, 7'd40,  32'h0, 0, 1, 7'd40,  0, 0));
    rows.push_back(r(N_CJ_INC, 0, CS_COND, 7'd40,  32'h0, 0, 0, 7'd41,  0, 0));
    rows.push_back(r(N_CJ_INC, 1, CS_ZERO, 7'd10,  32'h0, 0, 0, 7'd10,  0, 0));
    rows.push_back(r(N_CJ_INC, 1, CS_MOC,  7'd30,  32'h0, 1, 0, 7'd11,  0, 0));
    rows.push_back(r(N_CJ_INC, 0, CS_MOC,  7'd30,  32'h0, 1, 0, 7'd30,  0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
        errors++;
        $display("FAIL inc_cond[%0d]: got %0d/%b/%b want %0d/%b/%b", i, current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [6:0] t;
    for (int i = 0; i < 20; i++) begin
      t = 7'($urandom_range(0, 127));
      drive(r(N_JUMP, 0, CS_ZERO, t, 32'h0, 0, 0, t, 0, 0));
      e = sb.pop_front();
      vectors++;
      if (current_state !== e.st || illegal_op !== e.ill || mem_timeout !== e.to) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %0d/%b/%b want %0d/%b/%b", i, current_state, illegal_op, mem_timeout, e.st, e.ill, e.to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_wait_moc();
    test_wait_timeout();
    test_call_return();
    test_inc_cond();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
